// File: rtl/reg_wb_arbiter_pkg.sv
// Shared widths and grant encoding for the writeback arbiter and its scoreboard.
package reg_wb_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by decode allocation,
// cleared when the register file commits the write. Register 0 is never busy.
module reg_scoreboard #(
    parameter int unsigned AW = reg_wb_arbiter_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_i,
    input  logic [AW-1:0] set_addr_i,
    input  logic          clr_i,
    input  logic [AW-1:0] clr_addr_i,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    output logic          busy1_o,
    output logic          busy2_o
);

    localparam int unsigned NumRegs = 2 ** AW;

    logic [NumRegs-1:0] busy_q, busy_d;

    // Next busy vector: clear first so a same-edge set of the same address wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_i && (set_addr_i != '0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy bit storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard queries see registered state only; a same-cycle alloc is not bypassed.
    always_comb begin
        busy1_o = busy_q[ra1_i];
        busy2_o = busy_q[ra2_i];
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter between ALU and load writebacks, feeding a registered
// register-file write port, plus the pending-write scoreboard.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = reg_wb_arbiter_pkg::XLEN,
    parameter int unsigned AW   = reg_wb_arbiter_pkg::AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_valid_i,
    output logic            a_ready_o,
    input  logic [AW-1:0]   a_addr_i,
    input  logic [XLEN-1:0] a_data_i,
    input  logic            b_valid_i,
    output logic            b_ready_o,
    input  logic [AW-1:0]   b_addr_i,
    input  logic [XLEN-1:0] b_data_i,
    input  logic            alloc_valid_i,
    input  logic [AW-1:0]   alloc_addr_i,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic            busy1_o,
    output logic            busy2_o,
    output logic            we_o,
    output logic [AW-1:0]   wa_o,
    output logic [XLEN-1:0] wd_o
);

    grant_e          last_grant_q, last_grant_d;
    grant_e          grant;
    logic            xfer;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;
    logic            we_q, we_d;
    logic [AW-1:0]   wa_q, wa_d;
    logic [XLEN-1:0] wd_q, wd_d;

    // Grant selection, handshake outputs and next state of the write port.
    always_comb begin
        grant = GRANT_A;
        xfer  = 1'b0;
        if (a_valid_i && b_valid_i) begin
            xfer  = 1'b1;
            grant = (last_grant_q == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (a_valid_i) begin
            xfer  = 1'b1;
            grant = GRANT_A;
        end else if (b_valid_i) begin
            xfer  = 1'b1;
            grant = GRANT_B;
        end
        // No grants while held in reset.
        if (!rst_n) begin
            xfer = 1'b0;
        end

        a_ready_o = xfer && (grant == GRANT_A);
        b_ready_o = xfer && (grant == GRANT_B);

        win_addr = (grant == GRANT_A) ? a_addr_i : b_addr_i;
        win_data = (grant == GRANT_A) ? a_data_i : b_data_i;

        last_grant_d = xfer ? grant : last_grant_q;

        // x0 writes complete the handshake but never reach the register file.
        we_d = xfer && (win_addr != '0);
        wa_d = we_d ? win_addr : wa_q;
        wd_d = we_d ? win_data : wd_q;
    end

    // Round-robin pointer and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_B;
            we_q         <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
        end
    end

    // Drive the register-file write port from the output register.
    always_comb begin
        we_o = we_q;
        wa_o = wa_q;
        wd_o = wd_q;
    end

    // Busy bits clear on the edge where the register file commits we/wa.
    reg_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_i     (alloc_valid_i),
        .set_addr_i(alloc_addr_i),
        .clr_i     (we_q),
        .clr_addr_i(wa_q),
        .ra1_i     (ra1_i),
        .ra2_i     (ra2_i),
        .busy1_o   (busy1_o),
        .busy2_o   (busy2_o)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter.
module tb_reg_wb_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic            clk;
    logic            rst_n;
    logic            a_valid, a_ready;
    logic [AW-1:0]   a_addr;
    logic [XLEN-1:0] a_data;
    logic            b_valid, b_ready;
    logic [AW-1:0]   b_addr;
    logic [XLEN-1:0] b_data;
    logic            alloc_valid;
    logic [AW-1:0]   alloc_addr;
    logic [AW-1:0]   ra1, ra2;
    logic            busy1, busy2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;

    int checks = 0;
    int errors = 0;

    reg_wb_arbiter #(
        .XLEN(XLEN),
        .AW  (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid_i    (a_valid),
        .a_ready_o    (a_ready),
        .a_addr_i     (a_addr),
        .a_data_i     (a_data),
        .b_valid_i    (b_valid),
        .b_ready_o    (b_ready),
        .b_addr_i     (b_addr),
        .b_data_i     (b_data),
        .alloc_valid_i(alloc_valid),
        .alloc_addr_i (alloc_addr),
        .ra1_i        (ra1),
        .ra2_i        (ra2),
        .busy1_o      (busy1),
        .busy2_o      (busy2),
        .we_o         (we),
        .wa_o         (wa),
        .wd_o         (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        a_valid     = 1'b0;
        a_addr      = '0;
        a_data      = '0;
        b_valid     = 1'b0;
        b_addr      = '0;
        b_data      = '0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        ra1 = 5'd0;
        ra2 = 5'd3;
        rst_n = 1'b0;
        a_valid = 1'b1;
        a_addr  = 5'd4;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++; $display("FAIL reset_a_ready: got %b want 0", a_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we); end
        checks++;
        if (wa !== 5'd0) begin errors++; $display("FAIL reset_wa: got %0d want 0", wa); end
        checks++;
        if (wd !== 32'd0) begin errors++; $display("FAIL reset_wd: got %h want 0", wd); end
        checks++;
        if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy2); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 5'd5;
        a_data  = 32'hDEADBEEF;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_write: got we=%b wa=%0d wd=%h want 1 5 deadbeef", we, wa, wd);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (we !== 1'b0 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_hold: got we=%b wa=%0d wd=%h want 0 5 deadbeef", we, wa, wd);
        end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        logic [AW-1:0] exp_wa;
        logic [XLEN-1:0] exp_wd;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'hAAAA0001;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'hBBBB0002;
        for (int i = 0; i < 4; i++) begin
            exp_a  = (i % 2 == 0);
            exp_wa = exp_a ? 5'd1 : 5'd2;
            exp_wd = exp_a ? 32'hAAAA0001 : 32'hBBBB0002;
            #1;
            checks++;
            if (a_ready !== exp_a || b_ready !== !exp_a) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got a=%b b=%b want a=%b b=%b",
                         i, a_ready, b_ready, exp_a, !exp_a);
            end
            @(posedge clk); #1;
            checks++;
            if (we !== 1'b1 || wa !== exp_wa || wd !== exp_wd) begin
                errors++;
                $display("FAIL rr_write[%0d]: got we=%b wa=%0d wd=%h want 1 %0d %h",
                         i, we, wa, wd, exp_wa, exp_wd);
            end
            @(negedge clk);
        end
        idle_inputs();
        // Lone B after B was granted last must still win.
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h0000B006;
        #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            errors++; $display("FAIL rr_lone_b: got a=%b b=%b want a=0 b=1", a_ready, b_ready);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        alloc_valid = 1'b1; alloc_addr = 5'd7; ra1 = 5'd7;
        #1;
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_no_bypass: got %b want 0", busy1); end
        @(negedge clk);
        alloc_valid = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_set: got %b want 1", busy1); end
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h12345678;
        @(posedge clk); #1;
        checks++;
        if (we !== 1'b1 || wa !== 5'd7 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL sb_commit: got we=%b wa=%0d busy=%b want 1 7 1", we, wa, busy1);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b want 0", busy1); end
    endtask

    task automatic test_addr_zero();
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1;
        alloc_valid = 1'b1; alloc_addr = 5'd0; ra2 = 5'd0;
        #1;
        checks++;
        if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b want 1", a_ready); end
        @(posedge clk); #1;
        checks++;
        if (we !== 1'b0 || wa !== 5'd7 || wd !== 32'h12345678) begin
            errors++;
            $display("FAIL x0_no_write: got we=%b wa=%0d wd=%h want 0 7 12345678", we, wa, wd);
        end
        checks++;
        if (busy2 !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b want 0", busy2); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_set_clear_same();
        @(negedge clk);
        alloc_valid = 1'b1; alloc_addr = 5'd9; ra1 = 5'd9;
        @(negedge clk);
        alloc_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h00000009;
        @(negedge clk);
        a_valid = 1'b0;
        alloc_valid = 1'b1; alloc_addr = 5'd9;
        #1;
        checks++;
        if (we !== 1'b1 || wa !== 5'd9) begin
            errors++; $display("FAIL sc_setup: got we=%b wa=%0d want 1 9", we, wa);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL sc_set_wins: got %b want 1", busy1); end
        @(negedge clk);
        #1;
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL sc_stays: got %b want 1", busy1); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        alloc_valid = 1'b1; alloc_addr = 5'd4; ra1 = 5'd4; ra2 = 5'd9;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hCAFEF00D;
        @(posedge clk); #2;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_port: got we=%b wa=%0d wd=%h want 0 0 0", we, wa, wd);
        end
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++; $display("FAIL rst_mid_busy: got %b%b want 00", busy1, busy2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got we=%b want 0", we); end
        // Pointer back at B, so A must win contention.
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd1;
        b_valid = 1'b1; b_addr = 5'd2;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_grant: got a=%b b=%b want a=1 b=0", a_ready, b_ready);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        ra1 = '0;
        ra2 = '0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_scoreboard();
        test_addr_zero();
        test_set_clear_same();
        test_reset_midflight();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter AW, default 5, register address width (32 registers).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 a_valid/a_ready  in/out  1/1  ALU writeback handshake.
REQ-007 a_addr/a_data  in  AW/XLEN  ALU writeback target and value.
REQ-008 b_valid/b_ready  in/out  1/1  load-unit writeback handshake.
REQ-009 b_addr/b_data  in  AW/XLEN  load writeback target and value.
REQ-010 alloc_valid/alloc_addr  in  1/AW  decode marks destination register pending.
REQ-011 ra1/ra2  in  AW/AW  decode source addresses for hazard query.
REQ-012 busy1/busy2  out  1/1  source register has a pending write.
REQ-013 we/wa/wd  out  1/AW/XLEN  registered write port driving the register file.

Function
REQ-014 Transfer on a requester SHALL occur in a cycle where its valid and ready are both high.
REQ-015 a_ready/b_ready SHALL be combinational grants; at most one SHALL be high per cycle.
REQ-016 One requester valid: it SHALL be granted.
REQ-017 Both valid: grant SHALL go to the requester not granted most recently (round-robin pointer last_grant).
REQ-018 last_grant SHALL update on every transfer to the granted requester.
REQ-019 Transfer in cycle N SHALL drive we/wa/wd in cycle N+1 (one-cycle latency); no transfer -> we=0 in N+1.
REQ-020 Transfer with addr 0 SHALL complete the handshake but SHALL leave we=0 in N+1 (x0 never written).
REQ-021 wa/wd SHALL hold their last values when we=0.
REQ-022 Scoreboard: 2^AW busy bits; alloc_valid with alloc_addr!=0 SHALL set busy[alloc_addr] at the next edge.
REQ-023 Edge with we=1 SHALL clear busy[wa] (the edge the register file commits the write).
REQ-024 Simultaneous set and clear of the same address SHALL leave the bit set.
REQ-025 busy[0] SHALL be constant 0; alloc of address 0 SHALL be ignored.
REQ-026 busy1=busy[ra1], busy2=busy[ra2], combinational; no bypass of same-cycle alloc.
REQ-027 Alloc to an already-busy address SHALL keep it set; the first write clears it (decode stalls on busy destination, so this does not occur in use).
REQ-028 Requesters SHALL hold valid/addr/data stable until ready; the block does not buffer unaccepted requests.

Reset
REQ-029 rst_n low SHALL immediately force we=0, wa=0, wd=0, all busy bits 0, last_grant=B (A wins first contention).
REQ-030 a_ready/b_ready SHALL be 0 while rst_n is low.
REQ-031 Reset during a pending output write SHALL discard it; no write reaches the register file.
REQ-032 Deassertion SHALL be synchronized by the instantiating level; the block assumes a clean release.

Structure
REQ-033 Shared package SHALL hold XLEN, AW, and the grant encoding (GRANT_A=0, GRANT_B=1).
REQ-034 Scoreboard SHALL be a sub-module reg_scoreboard (set, clear, two query ports); arbitration and output register stay in reg_wb_arbiter.
REQ-035 Target size 150-250 lines RTL total.

Verification
REQ-036 Reset, then a_valid=1 a_addr=5 a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle we=1 wa=5 wd=0xDEADBEEF.
REQ-037 Both valid for 4 cycles (A addr 1, B addr 2) -> grants A,B,A,B; we cycles show wa=1,2,1,2.
REQ-038 alloc addr 7; ra1=7 -> busy1=1 next cycle; B writes addr 7 -> busy1=0 after the edge where we=1 wa=7.
REQ-039 A writes addr 0 data 0x1 -> a_ready=1, we stays 0; alloc addr 0 -> busy query of 0 stays 0.
REQ-040 Alloc addr 9 in the same cycle we=1 wa=9 -> busy[9]=1 afterwards.
REQ-041 Assert rst_n=0 in the cycle after a transfer -> we=0 immediately, all busy=0, no register written.
